// File: rtl/camera_emulator.sv
// camera_emulator: emulates a parallel-bus camera (PCLK/VSYNC/HREF/8-bit data) sending RGB565 frames.
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   enable             frame request, acted on only at frame boundaries
//   pattern_sel        0 colour bars, 1 pixel memory, 2 solid red, 3 8x8 checker
//   rd_addr, rd_data   pixel memory read port (RGB332 data one clock after address)
//   pclk               emulated pixel clock, clock/2
//   vsync, href        frame and line strobes, active high
//   cam_data           byte stream, low byte of each RGB565 word first
//   frame_done         one-clock pulse at the end of every frame
module camera_emulator #(
    parameter int H_PIXELS  = 176,
    parameter int V_LINES   = 144,
    parameter int H_BLANK   = 48,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 2,
    parameter int VFP_LINES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic [14:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  cam_data,
    output logic        frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_VS, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT} state_t;

    localparam logic [8:0]  LINE_END  = 9'(2 * H_PIXELS + H_BLANK - 1);
    localparam logic [8:0]  ACT_END   = 9'(2 * H_PIXELS - 1);
    localparam logic [7:0]  VS_END    = 8'(VS_LINES - 1);
    localparam logic [7:0]  VBP_END   = 8'(VBP_LINES - 1);
    localparam logic [7:0]  VFP_END   = 8'(VFP_LINES - 1);
    localparam logic [7:0]  LINES_END = 8'(V_LINES - 1);
    localparam logic [14:0] ADDR_END  = 15'(H_PIXELS * V_LINES - 1);
    localparam int          BAR       = H_PIXELS / 8;
    localparam logic [7:0]  BARS [8]  = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

    state_t      state, nxt;
    logic [8:0]  h;
    logic [7:0]  v, v_inc, nx, src, pix;
    logic [1:0]  pat;
    logic [15:0] word;
    logic        line_end, next_line, pix_start, cy;

    function automatic logic [7:0] bar_value(input logic [7:0] x);
        logic [2:0] b;
        b = 3'd0;
        for (int k = 1; k < 8; k++)
            if (x >= 8'(k * BAR)) b = 3'(k);
        return BARS[b];
    endfunction

    // Everything except pclk advances only on the edge where pclk falls (pclk currently 1),
    // so the bus is stable across every pclk rising edge.
    assign line_end  = (h == LINE_END);
    assign next_line = (state == S_HBLANK) && (nxt == S_ACTIVE);
    assign v_inc     = v + 8'd1;
    assign pix_start = pclk && (nxt == S_ACTIVE) && (state != S_ACTIVE || h[0]);

    // Coordinates of the pixel about to start (x = 0 when entering a line)
    assign nx  = (state == S_ACTIVE) ? h[8:1] + 8'd1 : 8'd0;
    assign cy  = (state == S_ACTIVE) ? v[3] : (state == S_HBLANK) ? v_inc[3] : 1'b0;
    assign src = (pat == 2'd0) ? bar_value(nx) :
                 (pat == 2'd1) ? rd_data :
                 (pat == 2'd2) ? 8'hE0 :
                 (nx[3] ^ cy)  ? 8'h00 : 8'hFF;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else if (pclk)
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = enable ? S_VS : S_IDLE;
            S_VS:     if (line_end && v == VS_END) nxt = S_VBACK;
            S_VBACK:  if (line_end && v == VBP_END) nxt = S_ACTIVE;
            S_ACTIVE: if (h == ACT_END) nxt = S_HBLANK;
            S_HBLANK: if (line_end) nxt = (v == LINES_END) ? S_VFRONT : S_ACTIVE;
            S_VFRONT: if (line_end && v == VFP_END) nxt = enable ? S_VS : S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        vsync    = (state == S_VS);
        href     = (state == S_ACTIVE);
        word     = {pix[7:5], pix[7:6], pix[4:2], pix[4:2], pix[1:0], pix[1:0], pix[1]};
        cam_data = href ? (h[0] ? word[15:8] : word[7:0]) : 8'h00;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pclk       <= 1'b0;
            frame_done <= 1'b0;
            h          <= 9'd0;
            v          <= 8'd0;
            pat        <= 2'd0;
            pix        <= 8'd0;
            rd_addr    <= 15'd0;
        end else begin
            pclk       <= ~pclk;
            frame_done <= pclk && state == S_VFRONT && nxt != S_VFRONT;
            if (pclk) begin
                h <= (state == S_IDLE || line_end) ? 9'd0 : h + 9'd1;
                // v counts lines inside a phase; in ACTIVE/HBLANK it is the active line index
                v <= (state == S_IDLE) ? 8'd0 :
                     !line_end ? v :
                     (nxt == state || next_line) ? v_inc : 8'd0;
                if (nxt == S_VS && state != S_VS) begin
                    pat     <= pattern_sel;
                    rd_addr <= 15'd0;
                end
                // Address always leads the shown pixel by one; after the last pixel of a line
                // it already points at the next line's first pixel, held through the blank.
                if (pix_start) begin
                    pix     <= src;
                    rd_addr <= (rd_addr == ADDR_END) ? rd_addr : rd_addr + 15'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_camera_emulator.sv
// tb_camera_emulator: directed self-checking bench for camera_emulator on a reduced frame size.
module tb_camera_emulator;
    localparam int HP    = 32;
    localparam int VL    = 16;
    localparam int HB    = 8;
    localparam int BAR   = HP / 8;
    localparam int LINE  = 2 * HP + HB;
    localparam int FRAME = (3 + 2 + VL + 2) * LINE;

    logic        clock = 1'b0;
    logic        reset, enable;
    logic [1:0]  pattern_sel;
    logic [14:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic        pclk, vsync, href, frame_done;
    logic [7:0]  cam_data;

    camera_emulator #(.H_PIXELS(HP), .V_LINES(VL), .H_BLANK(HB)) dut (
        .clock(clock), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .rd_addr(rd_addr), .rd_data(rd_data), .pclk(pclk), .vsync(vsync), .href(href),
        .cam_data(cam_data), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    logic       mem_const = 1'b1;
    logic [1:0] exp_pat = 2'd0;
    logic [7:0] bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    logic [7:0] line0 [2*HP];

    int fcnt = 0, frame_len = 0, vs_pclk = 0, lines = 0, len_err = 0, bi = 0;
    int byte_err = 0, zero_err = 0, stab_err = 0, fd_cnt = 0;
    int addr_err = 0, addr_steps = 0, addr_max = 0;
    logic prev_pclk = 0, prev_vs = 0, prev_href = 0;
    logic [7:0]  prev_cd = 0;
    logic [14:0] addr_prev = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_f(input logic [14:0] a);
        return mem_const ? 8'h1C : 8'(a * 15'd37) ^ a[10:3];
    endfunction

    function automatic logic [7:0] exp_byte(input logic [1:0] p, input int x, input int y, input logic hi);
        logic [7:0]  c;
        logic [15:0] w;
        c = (p == 2'd0) ? bars[x / BAR] :
            (p == 2'd1) ? mem_f(15'(y * HP + x)) :
            (p == 2'd2) ? 8'hE0 :
            (((x ^ y) & 8) != 0) ? 8'h00 : 8'hFF;
        w = {c[7:5], c[7:6], c[4:2], c[4:2], c[1:0], c[1:0], c[1]};
        return hi ? w[15:8] : w[7:0];
    endfunction

    // Registered pixel memory: data appears one clock after the address
    initial forever begin
        @(posedge clock);
        rd_data <= mem_f(rd_addr);
    end

    // Bus monitor, sampling on the falling clock edge
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (pclk && {vsync, href, cam_data} != {prev_vs, prev_href, prev_cd}) stab_err++;
            if (frame_done) begin
                fd_cnt++;
                frame_len = fcnt;
            end
            if (vsync && !prev_vs) begin
                fcnt = 0; vs_pclk = 0; lines = 0; len_err = 0; bi = 0;
                byte_err = 0; zero_err = 0; addr_err = 0; addr_steps = 0; addr_max = 0;
            end
            if (rd_addr != addr_prev) begin
                if (rd_addr == addr_prev + 15'd1) addr_steps++;
                else if (rd_addr != 15'd0) addr_err++;
            end
            if (int'(rd_addr) > addr_max) addr_max = int'(rd_addr);
            if (!href && prev_href) begin
                if (bi != 2 * HP) len_err++;
                lines++;
            end
            if (pclk && !prev_pclk) begin
                fcnt++;
                if (vsync) vs_pclk++;
                if (href) begin
                    if (bi >= 2 * HP) byte_err++;
                    else begin
                        if (cam_data !== exp_byte(exp_pat, bi / 2, lines, bi[0])) byte_err++;
                        if (lines == 0) line0[bi] = cam_data;
                    end
                    bi++;
                end else begin
                    if (cam_data != 8'h00) zero_err++;
                    bi = 0;
                end
            end
        end
        prev_pclk = pclk; prev_vs = vsync; prev_href = href; prev_cd = cam_data; addr_prev = rd_addr;
    end

    task automatic wait_fd(input int lim);
        int i;
        i = 0;
        while (!frame_done && i < lim) begin
            @(negedge clock);
            i++;
        end
        chk("frame_done_seen", frame_done, 1);
    endtask

    task automatic start_frame(input logic [1:0] p);
        exp_pat = p;
        pattern_sel = p;
        enable = 1'b1;
        for (int i = 0; i < 4 && !vsync; i++) @(negedge clock);
        chk("vsync_start", vsync, 1);
    endtask

    // One frame with enable dropped and pattern_sel disturbed right after it starts
    task automatic run_frame(input logic [1:0] p);
        int f0;
        f0 = fd_cnt;
        start_frame(p);
        enable = 1'b0;
        pattern_sel = ~p;
        wait_fd(2 * FRAME + 20);
        repeat (4) @(negedge clock);
        chk("fd_count", fd_cnt - f0, 1);
        chk("byte_err", byte_err, 0);
        chk("lines", lines, VL);
    endtask

    initial begin
        int tg, vs_hi;
        logic lp;
        reset = 1'b1;
        enable = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) @(negedge clock);
        chk("rst_pclk", pclk, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_href", href, 0);
        chk("rst_data", cam_data, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_addr", rd_addr, 0);
        reset = 1'b0;
        tg = 0;
        lp = pclk;
        repeat (10) begin
            @(negedge clock);
            if (pclk != lp) tg++;
            lp = pclk;
        end
        chk("idle_pclk_toggles", tg, 10);
        chk("idle_vsync", vsync, 0);

        run_frame(2'd2);
        chk("red_vs_pclk", vs_pclk, 3 * LINE);
        chk("red_frame_len", frame_len, FRAME);
        chk("red_len_err", len_err, 0);
        chk("red_zero_err", zero_err, 0);
        chk("red_b0", line0[0], 8'h00);
        chk("red_b1", line0[1], 8'hF8);
        chk("red_idle_vsync", vsync, 0);

        run_frame(2'd0);
        chk("bar_p0_lo", line0[0], 8'hFF);
        chk("bar_p0_hi", line0[1], 8'hFF);
        chk("bar_p4_lo", line0[8], 8'hE0);
        chk("bar_p4_hi", line0[9], 8'hFF);
        chk("bar_p8_lo", line0[16], 8'hFF);
        chk("bar_p8_hi", line0[17], 8'h07);
        chk("bar_last_lo", line0[2*HP-2], 8'h00);
        chk("bar_last_hi", line0[2*HP-1], 8'h00);

        run_frame(2'd3);
        chk("chk_p0", line0[0], 8'hFF);
        chk("chk_p8", line0[16], 8'h00);

        mem_const = 1'b1;
        run_frame(2'd1);
        chk("mem_b0", line0[0], 8'hE0);
        chk("mem_b1", line0[1], 8'h07);
        chk("mem_addr_err", addr_err, 0);
        chk("mem_addr_steps", addr_steps, HP * VL - 1);
        chk("mem_addr_max", addr_max, HP * VL - 1);

        mem_const = 1'b0;
        run_frame(2'd1);
        chk("memvar_addr_err", addr_err, 0);
        chk("memvar_addr_steps", addr_steps, HP * VL - 1);

        // Back-to-back frames, then enable dropped mid-frame
        start_frame(2'd2);
        wait_fd(2 * FRAME + 20);
        chk("restart_vsync", vsync, 1);
        @(negedge clock);
        chk("fd_one_clock", frame_done, 0);
        for (int i = 0; i < 2 * FRAME && lines < VL / 2; i++) @(negedge clock);
        chk("mid_frame_reached", lines >= VL / 2, 1);
        enable = 1'b0;
        wait_fd(2 * FRAME);
        chk("drop_lines", lines, VL);
        chk("drop_frame_len", frame_len, FRAME);
        chk("drop_byte_err", byte_err, 0);
        tg = 0;
        vs_hi = 0;
        lp = pclk;
        repeat (4 * LINE) begin
            @(negedge clock);
            if (pclk != lp) tg++;
            if (vsync) vs_hi++;
            lp = pclk;
        end
        chk("drop_idle_vsync", vs_hi, 0);
        chk("drop_pclk_toggles", tg, 4 * LINE);

        // Reset during an active line
        start_frame(2'd3);
        for (int i = 0; i < 2 * FRAME && !href; i++) @(negedge clock);
        repeat (10) @(negedge clock);
        chk("href_before_reset", href, 1);
        #3 reset = 1'b1;
        #1;
        chk("async_pclk", pclk, 0);
        chk("async_vsync", vsync, 0);
        chk("async_href", href, 0);
        chk("async_data", cam_data, 0);
        chk("async_done", frame_done, 0);
        chk("async_addr", rd_addr, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2 && !vsync; i++) @(negedge clock);
        chk("vsync_after_reset", vsync, 1);
        enable = 1'b0;
        wait_fd(2 * FRAME + 20);
        chk("post_reset_lines", lines, VL);
        chk("post_reset_byte_err", byte_err, 0);
        chk("post_reset_zero_err", zero_err, 0);

        chk("bus_stable", stab_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/camera_emulator.md
CAMERA_EMULATOR -- requirements
Module: camera_emulator

Interface
REQ-001 Parameter H_PIXELS, 176, active pixels per line.
REQ-002 Parameter V_LINES, 144, active lines per frame.
REQ-003 Parameter H_BLANK, 48, PCLK periods of HREF low after each active line.
REQ-004 Parameter VS_LINES / VBP_LINES / VFP_LINES, 3 / 2 / 2, line periods of VSYNC high / back porch / front porch.
REQ-005 CLOCK  in  1  single system clock; all logic SHALL run on its rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 ENABLE  in  1  frame generation request, sampled only at frame boundaries.
REQ-008 PATTERN_SEL  in  2  pixel source: 0 colour bars, 1 memory, 2 solid red, 3 black/white 8x8 checker.
REQ-009 RD_ADDR  out  15  pixel memory read address, x + y*H_PIXELS.
REQ-010 RD_DATA  in  8  RGB332 pixel from memory, valid one CLOCK after RD_ADDR.
REQ-011 PCLK  out  1  emulated camera pixel clock.
REQ-012 VSYNC  out  1  frame sync, active high.
REQ-013 HREF  out  1  line valid, active high.
REQ-014 CAM_DATA  out  8  byte stream, two bytes per pixel.
REQ-015 FRAME_DONE  out  1  one-CLOCK pulse at end of each frame.

Function
REQ-016 PCLK SHALL toggle every CLOCK cycle (CLOCK/2), free-running whenever RESET is low, including in IDLE.
REQ-017 VSYNC, HREF, CAM_DATA SHALL change only on the CLOCK edge where PCLK goes 1->0, so they are stable at every PCLK rising edge.
REQ-018 States: IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT; every line period is 2*H_PIXELS+H_BLANK = 400 PCLK periods.
REQ-019 IDLE -> VSYNC at the first PCLK falling edge with ENABLE high; VSYNC high, HREF low for VS_LINES line periods.
REQ-020 VSYNC -> VBACK: VSYNC low, HREF low for VBP_LINES line periods.
REQ-021 VBACK -> ACTIVE: HREF high for exactly 2*H_PIXELS PCLK periods; ACTIVE -> HBLANK: HREF low for H_BLANK periods; HBLANK -> ACTIVE until V_LINES lines are sent, then -> VFRONT.
REQ-022 VFRONT: VFP_LINES line periods with HREF and VSYNC low; at its end FRAME_DONE pulses for one CLOCK, then VSYNC if ENABLE is high, otherwise IDLE.
REQ-023 ENABLE falling mid-frame SHALL NOT truncate the frame; the current frame completes.
REQ-024 Each pixel SHALL be converted RGB332 -> RGB565 as R5={R3,R3[2:1]}, G6={G3,G3}, B5={B2,B2,B2[1]}.
REQ-025 Byte order per pixel: first byte = word[7:0] ({G6[2:0],B5}), second byte = word[15:8] ({R5,G6[5:3]}).
REQ-026 Colour bars: eight 22-pixel bars, left to right, with values FF, FC, 1F, 1C, E3, E0, 03, 00.
REQ-027 Checker: a pixel is FF when (x[3]^y[3])=0, otherwise 00.
REQ-028 Memory mode: RD_ADDR for pixel n SHALL be held during the four CLOCKs of pixel n-1.
REQ-029 RD_DATA SHALL be registered on the last of those four CLOCKs.
REQ-030 For pixel 0 of each line, the memory prefetch SHALL occur in the final four CLOCKs of the preceding blank or porch period.
REQ-031 RD_ADDR SHALL run 0..25343 per frame without gaps, return to 0 at each VSYNC entry, and never exceed 25343.
REQ-032 PATTERN_SEL SHALL be sampled at VSYNC entry and held for the whole frame.
REQ-033 CAM_DATA SHALL be 00 whenever HREF is low.

Reset
REQ-034 While RESET is high: PCLK=0, VSYNC=0, HREF=0, CAM_DATA=00, FRAME_DONE=0, RD_ADDR=0, state IDLE, all counters 0, taking effect immediately (asynchronous).
REQ-035 RESET asserted mid-line SHALL abort the frame with no completing bytes; after release, a new frame starts from VSYNC per REQ-019.

Verification
REQ-036 Assert RESET mid-ACTIVE -> all outputs reach reset values the same cycle; release with ENABLE=1 -> VSYNC rises within 2 CLOCKs.
REQ-037 ENABLE=1, PATTERN_SEL=2 -> VSYNC high 1200 PCLKs; 144 HREF pulses of 352 PCLK rises each; bytes alternate 00, F8.
REQ-038 PATTERN_SEL=1, RD_DATA model returns 1C -> bytes E0, 07; RD_ADDR sequence 0..25343 exact, one FRAME_DONE per 60400 PCLKs.
REQ-039 PATTERN_SEL=0 -> first line pixel 0 bytes FF, FF; pixel 22 bytes E0, FF; pixel 175 bytes 00, 00.
REQ-040 ENABLE dropped at line 70 -> frame finishes all 144 lines, FRAME_DONE pulses, state IDLE, VSYNC stays low, PCLK keeps toggling.
REQ-041 Loopback into the team's capture/downsample path with colour bars -> captured 176x144 RAM image matches the bar MSBs; all 144 rows written.
